// File: rtl/key_ctrl_pkg.sv
// Shared state encoding, default cycle constants and key levels for the attempt sequencer.
package key_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_COOLDOWN,
    ST_LOCKED,
    ST_OPEN
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_COOLDOWN_CYCLES = 25000000;
  localparam int DEF_LOCKOUT_CYCLES  = 250000000;
  localparam int DEF_MAX_FAILS       = 3;

  localparam int TIMER_W = 28;

  localparam logic [2:0] KEY_IDLE = 3'b111;

  // Down-counter reload value: timer expires after exactly 'cycles' cycles in the state.
  function automatic logic [TIMER_W-1:0] timer_load(input int cycles);
    return TIMER_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/key_attempt_ctrl_if.sv
// Button / key_checker signal bundle; master is the sequencer side, slave the board/checker side.
interface key_attempt_ctrl_if;

  logic [2:0]  key_raw;
  logic [2:0]  btn_out;
  logic        chk_rst;
  logic        chk_success;
  logic        chk_fail;
  logic        unlocked;
  logic        fail_flag;
  logic        locked;
  logic [3:0]  fail_cnt;
  logic [15:0] attempt_cnt;

  modport master (
    input  key_raw, chk_success, chk_fail,
    output btn_out, chk_rst, unlocked, fail_flag, locked, fail_cnt, attempt_cnt
  );

  modport slave (
    output key_raw, chk_success, chk_fail,
    input  btn_out, chk_rst, unlocked, fail_flag, locked, fail_cnt, attempt_cnt
  );

endinterface

// File: rtl/key_debounce.sv
// One-bit 2-flop synchronizer plus debounce counter; output follows the synced input after
// DEBOUNCE_CYCLES consecutive stable cycles (2 + DEBOUNCE_CYCLES from raw edge). Released = 1.
module key_debounce
  import key_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key_raw,
  output logic o_key_deb
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_deb;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_deb   <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_key_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_key_deb = r_deb;

endmodule

// File: rtl/key_attempt_ctrl.sv
// Attempt sequencer: debounces KEYs into key_checker, counts results, and applies
// cooldown after a failure, lockout after MAX_FAILS failures, and a terminal OPEN on success.
module key_attempt_ctrl
  import key_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
  parameter int LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES,
  parameter int MAX_FAILS       = DEF_MAX_FAILS
) (
  input logic               clk,
  input logic               rst,
  key_attempt_ctrl_if.master bus
);

  localparam logic [3:0] FAIL_LIMIT = 4'(MAX_FAILS);

  logic [2:0]         w_deb;
  logic               w_succ_edge;
  logic               w_fail_edge;
  logic [3:0]         w_fail_cnt_nxt;
  logic               w_keys_released;
  logic               w_timer_done;

  state_t             r_state;
  logic [TIMER_W-1:0] r_timer;
  logic               r_succ_q;
  logic               r_fail_q;
  logic               r_fwd_en;
  logic               r_chk_rst;
  logic               r_unlocked;
  logic               r_fail_flag;
  logic               r_locked;
  logic [3:0]         r_fail_cnt;
  logic [15:0]        r_attempt_cnt;

  for (genvar gi = 0; gi < 3; gi++) begin : g_deb
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk       (clk),
      .rst       (rst),
      .i_key_raw (bus.key_raw[gi]),
      .o_key_deb (w_deb[gi])
    );
  end

  assign w_succ_edge     = bus.chk_success & ~r_succ_q;
  assign w_fail_edge     = bus.chk_fail & ~r_fail_q;
  assign w_fail_cnt_nxt  = r_fail_cnt + 4'd1;
  assign w_keys_released = (w_deb == KEY_IDLE);
  assign w_timer_done    = (r_timer == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_INIT;
      r_timer       <= '0;
      r_succ_q      <= 1'b0;
      r_fail_q      <= 1'b0;
      r_fwd_en      <= 1'b0;
      r_chk_rst     <= 1'b1;
      r_unlocked    <= 1'b0;
      r_fail_flag   <= 1'b0;
      r_locked      <= 1'b0;
      r_fail_cnt    <= '0;
      r_attempt_cnt <= '0;
    end else begin
      // A checker held in reset cannot report, so its stale result levels are dropped.
      r_succ_q <= r_chk_rst ? 1'b0 : bus.chk_success;
      r_fail_q <= r_chk_rst ? 1'b0 : bus.chk_fail;

      case (r_state)
        ST_INIT: begin
          r_state   <= ST_IDLE;
          r_chk_rst <= 1'b0;
          r_fwd_en  <= 1'b1;
        end

        ST_IDLE: begin
          if (w_succ_edge) begin
            r_state       <= ST_OPEN;
            r_attempt_cnt <= r_attempt_cnt + 16'd1;
            r_unlocked    <= 1'b1;
            r_chk_rst     <= 1'b1;
            r_fwd_en      <= 1'b0;
          end else if (w_fail_edge) begin
            r_attempt_cnt <= r_attempt_cnt + 16'd1;
            r_fail_cnt    <= w_fail_cnt_nxt;
            r_chk_rst     <= 1'b1;
            r_fwd_en      <= 1'b0;
            r_fail_flag   <= 1'b1;
            if (w_fail_cnt_nxt == FAIL_LIMIT) begin
              r_state  <= ST_LOCKED;
              r_locked <= 1'b1;
              r_timer  <= timer_load(LOCKOUT_CYCLES);
            end else begin
              r_state <= ST_COOLDOWN;
              r_timer <= timer_load(COOLDOWN_CYCLES);
            end
          end
        end

        ST_COOLDOWN, ST_LOCKED: begin
          if (!w_timer_done) begin
            r_timer <= r_timer - 1'b1;
          end else begin
            if (r_state == ST_LOCKED) begin
              r_fail_cnt <= '0;
            end
            // Held keys must be let go first so a stuck press never counts as a new attempt.
            if (w_keys_released) begin
              r_state     <= ST_IDLE;
              r_chk_rst   <= 1'b0;
              r_fwd_en    <= 1'b1;
              r_fail_flag <= 1'b0;
              r_locked    <= 1'b0;
            end
          end
        end

        ST_OPEN: begin
          r_state <= ST_OPEN;
        end

        default: begin
          r_state   <= ST_INIT;
          r_chk_rst <= 1'b1;
          r_fwd_en  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.btn_out     = r_fwd_en ? w_deb : KEY_IDLE;
  assign bus.chk_rst     = r_chk_rst;
  assign bus.unlocked    = r_unlocked;
  assign bus.fail_flag   = r_fail_flag;
  assign bus.locked      = r_locked;
  assign bus.fail_cnt    = r_fail_cnt;
  assign bus.attempt_cnt = r_attempt_cnt;

endmodule
